// File: rtl/vga_fb_pkg.sv
// Shared definitions for the frame-buffer scan-out reader: FSM state codes,
// default raster geometry and the layout of a prefetch FIFO entry.
package vga_fb_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_V_ACTIVE = 480;

    // FSM state encoding (IDLE / RUN / DRAIN)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Pixel flags; a FIFO entry is {pix_flags_t, data}, flags above the data
    typedef struct packed {
        logic eof;
        logic eol;
        logic sof;
    } pix_flags_t;

    localparam int unsigned FLAG_BITS = $bits(pix_flags_t);

endpackage

// File: rtl/vga_fb_if.sv
// Frame-buffer reader bus: frame request, memory read port and pixel stream.
//   master : the reader (drives memory address and pixel stream)
//   slave  : control / memory / consumer side
interface vga_fb_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  pix_sof;
    logic                  pix_eol;
    logic                  pix_eof;
    logic                  busy;
    logic                  frame_done;

    modport master (
        input  start, base_addr, mem_data_in, pix_ready,
        output mem_addr_out, pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
               busy, frame_done
    );

    modport slave (
        output start, base_addr, mem_data_in, pix_ready,
        input  mem_addr_out, pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
               busy, frame_done
    );
endinterface

// File: rtl/vga_fb_fifo.sv
// Prefetch FIFO for the scan-out reader. Register storage, head visible
// without a pop. Caller never pushes when full unless it also pops.
//   clk, reset : clock, synchronous active-high reset (empties, zeroes storage)
//   push/push_data, pop : write and read strobes
//   head : oldest entry; empty / full : occupancy status
module vga_fb_fifo #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Storage and pointers; pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/vga_fb_reader.sv
// Frame-buffer scan-out reader. On start, reads one frame in raster order
// from base_addr through an asynchronous memory read port, buffers pixels in
// a prefetch FIFO and presents them as a flagged valid/ready stream.
//   clk, reset : clock, synchronous active-high reset
//   bus        : vga_fb_if.master (start/base_addr, memory port, pixel stream,
//                busy, frame_done)
module vga_fb_reader
    import vga_fb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic   clk,
    input logic   reset,
    vga_fb_if.master bus
);
    localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int unsigned XW    = $clog2(H_ACTIVE + 1);
    localparam int unsigned YW    = $clog2(V_ACTIVE + 1);
    localparam int unsigned IW    = $clog2(TOTAL + 1);
    localparam int unsigned EW    = DATA_WIDTH + FLAG_BITS;

    logic [1:0]            state, state_nxt;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [IW-1:0]         idx;
    logic                  busy_r;
    logic                  done_r;

    logic                  fifo_full, fifo_empty;
    logic [EW-1:0]         fifo_head;
    pix_flags_t            head_flags;
    pix_flags_t            push_flags;
    logic                  pop, rd_en, push, last_capture, eof_pop;

    assign head_flags = pix_flags_t'(fifo_head[EW-1:DATA_WIDTH]);

    // Read step, flag generation and next-state decode
    always_comb begin
        pop          = !fifo_empty && bus.pix_ready;
        rd_en        = !fifo_full || pop;
        push         = (state == ST_RUN) && rd_en;
        last_capture = push && (x == XW'(H_ACTIVE - 1)) && (y == YW'(V_ACTIVE - 1));
        eof_pop      = pop && head_flags.eof;
        push_flags.sof = (idx == '0);
        push_flags.eol = (x == XW'(H_ACTIVE - 1));
        push_flags.eof = (idx == IW'(TOTAL - 1));
        state_nxt    = state;
        case (state)
            ST_IDLE:  if (bus.start)   state_nxt = ST_RUN;
            ST_RUN:   if (last_capture) state_nxt = ST_DRAIN;
            ST_DRAIN: if (eof_pop)     state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Counters, address register and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            base_r <= '0;
            addr_r <= '0;
            x      <= '0;
            y      <= '0;
            idx    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt != ST_IDLE);
            done_r <= (state == ST_DRAIN) && eof_pop;
            if ((state == ST_IDLE) && bus.start) begin
                base_r <= bus.base_addr;
                addr_r <= bus.base_addr;
                x      <= '0;
                y      <= '0;
                idx    <= '0;
            end else if (push) begin
                idx <= idx + IW'(1);
                if (x == XW'(H_ACTIVE - 1)) begin
                    x <= '0;
                    y <= y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
                // Final address is held through DRAIN and IDLE
                if (!last_capture) addr_r <= base_r + ADDR_WIDTH'(idx + IW'(1));
            end
        end
    end

    vga_fb_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({push_flags, bus.mem_data_in}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.mem_addr_out = addr_r;
    assign bus.pix_data     = fifo_head[DATA_WIDTH-1:0];
    assign bus.pix_valid    = !fifo_empty;
    // Flags are qualified so a stale entry never shows a flag
    assign bus.pix_sof      = !fifo_empty && head_flags.sof;
    assign bus.pix_eol      = !fifo_empty && head_flags.eol;
    assign bus.pix_eof      = !fifo_empty && head_flags.eof;
    assign bus.busy         = busy_r;
    assign bus.frame_done   = done_r;

endmodule

// File: doc/vga_fb_reader.md
# vga_fb_reader

Frame-buffer scan-out reader for the VGA controller. On `start` it reads one full frame from the pixel memory's asynchronous read port, `addr_out` to `data_out`, in raster order starting at a programmable base address. It buffers the pixels in a small prefetch FIFO and presents them on a valid/ready pixel stream tagged with start-of-frame, end-of-line and end-of-frame flags. It sits between the pixel memory and the VGA timing/output stage and is the read-side counterpart of the memory's write port.

## Interface
- `DATA_WIDTH`, 32, pixel word width; must match the memory.
- `ADDR_WIDTH`, 32, memory address width.
- `H_ACTIVE`, 640, pixels per line.
- `V_ACTIVE`, 480, lines per frame.
- `FIFO_DEPTH`, 4, prefetch entries; power of two, at least 2.
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle request to scan one frame; honoured only in IDLE.
- `base_addr` input ADDR_WIDTH: frame base address, sampled when `start` is accepted.
- `mem_addr_out` output ADDR_WIDTH: drives the memory `addr_out`.
- `mem_data_in` input DATA_WIDTH: from the memory `data_out`; combinational with `mem_addr_out`.
- `pix_data` output DATA_WIDTH: FIFO head pixel.
- `pix_valid` output 1: `pix_data` and flags are valid.
- `pix_ready` input 1: consumer accepts the head when `pix_valid & pix_ready`.
- `pix_sof`, `pix_eol`, `pix_eof` output 1 each: head pixel is the first pixel of the frame, the last pixel of a line, or the last pixel of the frame.
- `busy` output 1: high in RUN and DRAIN.
- `frame_done` output 1: one-cycle pulse when the last pixel of the frame is accepted.

## Operation
- States:
  - IDLE: `start` moves to RUN. `base_r <= base_addr`, `x`, `y` and `idx` cleared.
  - RUN: after the final address is captured, moves to DRAIN.
  - DRAIN: when the FIFO empties through the last pop, moves to IDLE.
- Read step (`rd_en`) in RUN: `rd_en = !fifo_full | pop`.
  - When `rd_en` is high, `mem_data_in` is pushed together with the flags `sof = (idx==0)`, `eol = (x==H_ACTIVE-1)` and `eof = (idx==H_ACTIVE*V_ACTIVE-1)`.
  - The counters then advance: `x` wraps at H_ACTIVE and increments `y`, and `idx` increments.
- `mem_addr_out` is the registered value `base_r + idx`. Arithmetic is modulo 2^ADDR_WIDTH, so it wraps silently past all-ones.
- `mem_addr_out` holds its value in IDLE and DRAIN.
- `pix_valid` is equal to FIFO not-empty. The head pixel and its flags stay stable while `pix_valid & !pix_ready`.
- A pop of the entry flagged `eof` pulses `frame_done` in the following cycle and returns the block to IDLE.
- `start` in RUN or DRAIN is ignored and has no side effect.
- Simultaneous push and pop on a full FIFO is allowed; occupancy is unchanged.
- `reset` in any state:
  - returns to IDLE and empties the FIFO;
  - clears counters;
  - drops all flags and `frame_done`.
  - Pixels in flight are discarded.

## Timing
- Reset values:
  - `mem_addr_out=0`, `pix_data=0`, `pix_valid=0`;
  - `pix_sof`, `pix_eol`, `pix_eof` = 0;
  - `busy=0`, `frame_done=0`.
- Start latency: `start` accepted in cycle T.
  - `busy` and `mem_addr_out=base_addr` are valid in T+1, with the first capture at the end of T+1.
  - `pix_valid` rises in T+2.
- Throughput is 1 pixel/cycle sustained with `pix_ready` held high. Frame accepted after T+2, at T+1+H_ACTIVE*V_ACTIVE.
- `frame_done` is asserted the cycle after the `eof` handshake, with `busy` low in that same cycle. A new `start` is accepted in that cycle.
- Memory data is sampled in the same cycle its address is driven; there is no read pipeline.

## Structure
- Shared package `vga_fb_pkg`:
  - state enum (IDLE/RUN/DRAIN);
  - FIFO entry field positions (flags concatenated above the data);
  - default H_ACTIVE/V_ACTIVE constants.
- Sub-module `vga_fb_fifo`: synchronous FIFO with FIFO_DEPTH entries of DATA_WIDTH+3 bits, using the same `clk` and `reset`.
- The top level holds the FSM, counters and address adder.

## Test plan
- Reset and idle: after `reset`, all outputs are 0. `pix_ready=1` with no `start` gives no `pix_valid` for 20 cycles.
- Small frame: H_ACTIVE=4, V_ACTIVE=3, memory[i]=i, `base_addr=0x100`, `pix_ready=1`.
  - Required order: data 0..11 from addresses 0x100..0x10B.
  - `sof` on pixel 0, `eol` on 3/7/11, `eof` on 11, `frame_done` in the cycle after pixel 11.
- Backpressure: `pix_ready` toggled randomly and held low for 10 cycles.
  - No pixel is lost or duplicated, the head stays stable while stalled, and no more than FIFO_DEPTH reads run ahead.
- `start` pulsed mid-frame: ignored, `base_r` is unchanged and the frame completes normally. A `start` in the `frame_done` cycle launches the next frame.
- Reset mid-frame at pixel 5: the cycle after `reset` shows `pix_valid=0`, `busy=0`, `mem_addr_out=0`. A restarted frame begins again from `sof`.
- Address wrap: ADDR_WIDTH=8, `base_addr=0xFE`, 4x1 frame. Addresses must be 0xFE, 0xFF, 0x00, 0x01.
